// File: rtl/mem_responder.sv
// Memory-side responder for the core's single-port request bus: word array answering
// each accepted read/write after a fixed latency, driving the shared Data bus only for reads.
module mem_responder #(
  parameter int    MEM_DEPTH  = 64,
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 32,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Addr,
  inout  wire  [DATA_WIDTH-1:0] Data,
  input  logic                  we,
  input  logic                  req_valid,
  output logic                  data_valid
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_p0;
  logic                  we_p0;
  logic                  oor_p0;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      req_idx;
  logic                  req_oor;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr_lsbs;

  // Byte lanes are ignored; anything above the index field is out of range.
  assign req_idx          = Addr[IDX_W+1:2];
  assign req_oor          = |Addr[ADDR_WIDTH-1:IDX_W+2];
  assign accept           = !reset && (state == IDLE) && req_valid;
  assign unused_addr_lsbs = ^Addr[1:0];

  // Control: request FSM and latency counter; data_valid is the registered RESP decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          if (req_valid) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            data_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          data_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

  // Request latch stage: index, direction and range flag held for the response.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      idx_p0 <= req_idx;
      we_p0  <= we;
      oor_p0 <= req_oor;
    end
  end

  // Writes commit at acceptance so a following read sees the new word.
  always_ff @(posedge clk) begin
    if (accept && we && !req_oor) mem[req_idx] <= Data;
  end

  assign rd_word = oor_p0 ? '0 : mem[idx_p0];
  assign Data    = (data_valid && !we_p0) ? rd_word : 'z;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 2, 1 and 15: table of single transactions
// plus hand-written back-to-back and mid-request reset sequences.
module tb_mem_responder;

  localparam logic [31:0] ZVAL = 32'hFFFF_FFFF;  // pulled-up idle bus value
  localparam int NV = 14;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr     [3];
  logic        we_s     [3];
  logic        rv       [3];
  logic        drv_en   [3];
  logic [31:0] drv_data [3];
  logic        dv       [3];
  tri1  [31:0] bus0, bus1, bus2;

  int errs   = 0;
  int checks = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  assign bus0 = drv_en[0] ? drv_data[0] : 'z;
  assign bus1 = drv_en[1] ? drv_data[1] : 'z;
  assign bus2 = drv_en[2] ? drv_data[2] : 'z;

  mem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .Addr(addr[0]), .Data(bus0),
    .we(we_s[0]), .req_valid(rv[0]), .data_valid(dv[0]));
  mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .Addr(addr[1]), .Data(bus1),
    .we(we_s[1]), .req_valid(rv[1]), .data_valid(dv[1]));
  mem_responder #(.LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .Addr(addr[2]), .Data(bus2),
    .we(we_s[2]), .req_valid(rv[2]), .data_valid(dv[2]));

  function automatic int lat_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] bus_of(input int u);
    case (u)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; the next edge accepts the request.
  task automatic xact(input int u, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [31:0] exp, input string nm);
    int l = lat_of(u);
    addr[u] = a; we_s[u] = w; rv[u] = 1'b1; drv_en[u] = w; drv_data[u] = wd;
    for (int n = 0; n <= l; n++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s/L%0d dv@%0d", nm, l, n), 32'(dv[u]), (n == l) ? 32'd1 : 32'd0);
      check($sformatf("%s/L%0d bus@%0d", nm, l, n), bus_of(u),
            w ? wd : ((n == l) ? exp : ZVAL));
    end
    rv[u] = 1'b0; drv_en[u] = 1'b0; we_s[u] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s/L%0d dv after", nm, l), 32'(dv[u]), 32'd0);
    check($sformatf("%s/L%0d bus after", nm, l), bus_of(u), ZVAL);
    @(posedge clk);
    #1;
  endtask

  task automatic b2b(input int u);
    logic [31:0] exp_d [3];
    int l = lat_of(u);
    int cyc;
    exp_d[0] = 32'h1111_1111; exp_d[1] = 32'h2222_2222; exp_d[2] = 32'h3333_3333;
    we_s[u] = 1'b0; drv_en[u] = 1'b0; rv[u] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      addr[u] = 32'(4 * j);
      cyc = 0;
      do begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end while (!dv[u] && cyc < l + 6);
      check($sformatf("b2b%0d/L%0d spacing", j, l), 32'(cyc), 32'((j == 0) ? l + 1 : l + 2));
      check($sformatf("b2b%0d/L%0d data", j, l), bus_of(u), exp_d[j]);
    end
    rv[u] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("b2b/L%0d dv after", l), 32'(dv[u]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid(input int u);
    int l = lat_of(u);
    int seen = 0;
    addr[u] = 32'h8; we_s[u] = 1'b0; rv[u] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1; rv[u] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < l + 3; n++) begin
      @(negedge clk);
      if (dv[u]) seen++;
      @(posedge clk);
    end
    #1;
    check($sformatf("rstmid/L%0d pulses", l), 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h0000_000C, 1'b1, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{32'h0000_0010, 1'b1, 32'h1234_5678, 32'h0};
    tbl[2]  = '{32'h0000_0000, 1'b1, 32'h1111_1111, 32'h0};
    tbl[3]  = '{32'h0000_0004, 1'b1, 32'h2222_2222, 32'h0};
    tbl[4]  = '{32'h0000_0008, 1'b1, 32'h3333_3333, 32'h0};
    tbl[5]  = '{32'h0000_00FF, 1'b1, 32'hA5A5_5A5A, 32'h0};
    tbl[6]  = '{32'h0000_000C, 1'b0, 32'h0,         32'hDEAD_BEEF};
    tbl[7]  = '{32'h0000_0010, 1'b0, 32'h0,         32'h1234_5678};
    tbl[8]  = '{32'h0000_0013, 1'b0, 32'h0,         32'h1234_5678};
    tbl[9]  = '{32'h0000_00FC, 1'b0, 32'h0,         32'hA5A5_5A5A};
    tbl[10] = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{32'h0000_0100, 1'b0, 32'h0,         32'h0000_0000};
    tbl[12] = '{32'h8000_0000, 1'b0, 32'h0,         32'h0000_0000};
    tbl[13] = '{32'h0000_0000, 1'b0, 32'h0,         32'h1111_1111};

    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      addr[u] = 32'h0; we_s[u] = 1'b0; rv[u] = 1'b0; drv_en[u] = 1'b0; drv_data[u] = 32'h0;
    end
    rv[0] = 1'b1; addr[0] = 32'h100;
    repeat (2) @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("reset dv@%0d", n), 32'(dv[0]), 32'd0);
      check($sformatf("reset bus@%0d", n), bus0, ZVAL);
      check($sformatf("reset dv L1@%0d", n), 32'(dv[1]), 32'd0);
      check($sformatf("reset dv L15@%0d", n), 32'(dv[2]), 32'd0);
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    xact(0, 32'h100, 1'b0, 32'h0, 32'h0, "rst-release");

    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < NV; i++)
        xact(u, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].exp, $sformatf("v%0d", i));
      b2b(u);
      reset_mid(u);
      xact(u, 32'h8, 1'b0, 32'h0, 32'h3333_3333, "post-rst");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
